// File: rtl/writeback_unit.sv
// Write side of the register file: selects and extends the
// result of a retiring instruction and drives IR/load/data.
// Ports:
//   i_clk, i_rst        clock, async active-high reset
//   i_valid, o_ready    accept handshake (accept in IDLE)
//   i_IR, i_alu_result  instruction word, ALU result / load addr
//   i_pc                PC of the instruction
//   i_mem_rdata/ack     aligned load word with 1-cycle ack
//   o_rf_IR/load/data   register file write port
//   o_done, o_err       retire pulse and error flag
module writeback_unit #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [31:0] i_IR,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ack,
  output logic        o_ready,
  output logic [31:0] o_rf_IR,
  output logic        o_rf_load,
  output logic [31:0] o_rf_data,
  output logic        o_done,
  output logic        o_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE
  } state_t;

  localparam logic [15:0] TMO = 16'(MEM_TIMEOUT);

  state_t      state_q;
  logic [31:0] ir_q;
  logic [31:0] alu_q;
  logic [31:0] pc_q;
  logic        load_q;
  logic [31:0] data_q;
  logic        done_q;
  logic        err_q;
  logic [15:0] cnt_q;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [1:0]  off;
  logic        rd_nz;
  logic        wr_alu;
  logic        wr_pc4;
  logic        is_load;
  logic        bad_op;
  logic        ld_ok;
  logic [31:0] sh_b;
  logic [31:0] sh_h;
  logic [31:0] ext_d;
  logic [15:0] cnt_d;

  assign opc   = ir_q[6:0];
  assign f3    = ir_q[14:12];
  assign off   = alu_q[1:0];
  assign rd_nz = (ir_q[11:7] != 5'd0);
  assign cnt_d = cnt_q + 16'd1;

  always_comb begin
    wr_alu  = 1'b0;
    wr_pc4  = 1'b0;
    is_load = 1'b0;
    bad_op  = 1'b0;
    case (opc)
      7'b0110011, 7'b0010011,
      7'b0110111, 7'b0010111: wr_alu = 1'b1;
      7'b1101111, 7'b1100111: wr_pc4 = 1'b1;
      7'b1100011, 7'b0100011,
      7'b1110011, 7'b0001111: ;
      7'b0000011:             is_load = 1'b1;
      default:                bad_op = 1'b1;
    endcase
  end

  always_comb begin
    case (f3)
      3'b000, 3'b100: ld_ok = 1'b1;
      3'b001, 3'b101: ld_ok = ~off[0];
      3'b010:         ld_ok = (off == 2'b00);
      default:        ld_ok = 1'b0;
    endcase
  end

  // Byte/half lanes are shifted down to bit 0 before extension.
  always_comb begin
    sh_b = i_mem_rdata >> {off, 3'b000};
    sh_h = i_mem_rdata >> {off[1], 4'b0000};
    case (f3)
      3'b000:  ext_d = {{24{sh_b[7]}}, sh_b[7:0]};
      3'b100:  ext_d = {24'd0, sh_b[7:0]};
      3'b001:  ext_d = {{16{sh_h[15]}}, sh_h[15:0]};
      3'b101:  ext_d = {16'd0, sh_h[15:0]};
      default: ext_d = i_mem_rdata;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      alu_q   <= '0;
      pc_q    <= '0;
      load_q  <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      load_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            ir_q    <= i_IR;
            alu_q   <= i_alu_result;
            pc_q    <= i_pc;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (is_load && ld_ok) begin
            cnt_q   <= '0;
            state_q <= S_WAIT;
          end else begin
            done_q  <= 1'b1;
            err_q   <= bad_op | is_load;
            load_q  <= (wr_alu | wr_pc4) & rd_nz;
            if (wr_alu)
              data_q <= alu_q;
            else if (wr_pc4)
              data_q <= pc_q + 32'd4;
            state_q <= S_WRITE;
          end
        end
        S_WAIT: begin
          // An ack on the timeout cycle still completes the load.
          if (i_mem_ack) begin
            data_q  <= ext_d;
            load_q  <= rd_nz;
            done_q  <= 1'b1;
            state_q <= S_WRITE;
          end else if (cnt_d == TMO) begin
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= S_WRITE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_ready   = (state_q == S_IDLE);
  assign o_rf_IR   = ir_q;
  assign o_rf_load = load_q;
  assign o_rf_data = data_q;
  assign o_done    = done_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed cases plus random
// instructions scored against a behavioural result model.
module tb_writeback_unit;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [31:0] ir;
  logic [31:0] alu;
  logic [31:0] pc;
  logic [31:0] rdata;
  logic        ack;
  logic        ready;
  logic [31:0] rf_ir;
  logic        rf_load;
  logic [31:0] rf_data;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [31:0] rf [32];
  logic [31:0] obs_data;
  logic        obs_load;
  logic        obs_err;

  writeback_unit #(.MEM_TIMEOUT(T)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_valid(valid),
    .i_IR(ir),
    .i_alu_result(alu),
    .i_pc(pc),
    .i_mem_rdata(rdata),
    .i_mem_ack(ack),
    .o_ready(ready),
    .o_rf_IR(rf_ir),
    .o_rf_load(rf_load),
    .o_rf_data(rf_data),
    .o_done(done),
    .o_err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rf_load) rf[rf_ir[11:7]] <= rf_data;

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Expected outcome from the instruction semantics.
  // k: negedges after acceptance until o_done is seen.
  task automatic model(input logic [31:0] i_ir,
                       input logic [31:0] a,
                       input logic [31:0] p,
                       input logic [31:0] rd_w,
                       input int ackc,
                       output int k,
                       output logic ld,
                       output logic [31:0] d,
                       output logic e);
    logic [6:0] op;
    logic [2:0] fn;
    int ofs;
    logic [7:0] b;
    logic [15:0] h;
    bit wr;
    bit ok;
    op = i_ir[6:0];
    fn = i_ir[14:12];
    ofs = int'(a[1:0]);
    k = 1; ld = 0; d = 'x; e = 0; wr = 0;
    if (op == 7'h33 || op == 7'h13 ||
        op == 7'h37 || op == 7'h17) begin
      wr = 1; d = a;
    end else if (op == 7'h6F || op == 7'h67) begin
      wr = 1; d = p + 4;
    end else if (op == 7'h63 || op == 7'h23 ||
                 op == 7'h73 || op == 7'h0F) begin
      wr = 0;
    end else if (op == 7'h03) begin
      ok = (fn == 0 || fn == 4) ||
           ((fn == 1 || fn == 5) && ofs % 2 == 0) ||
           (fn == 2 && ofs == 0);
      if (!ok) e = 1;
      else if (ackc <= T) begin
        k = ackc + 1;
        wr = 1;
        b = rd_w[ofs*8 +: 8];
        h = rd_w[(ofs/2)*16 +: 16];
        case (fn)
          3'd0: d = {{24{b[7]}}, b};
          3'd4: d = {24'd0, b};
          3'd1: d = {{16{h[15]}}, h};
          3'd5: d = {16'd0, h};
          default: d = rd_w;
        endcase
      end else begin
        k = T + 1; e = 1;
      end
    end else e = 1;
    ld = wr && (i_ir[11:7] != 0);
  endtask

  task automatic run(input logic [31:0] i_ir,
                     input logic [31:0] a,
                     input logic [31:0] p,
                     input logic [31:0] rd_w,
                     input int ackc);
    int k, ek;
    logic eld, eer;
    logic [31:0] ed;
    bit seen, early;
    model(i_ir, a, p, rd_w, ackc, ek, eld, ed, eer);
    chk("ready_before", 32'(ready), 32'd1);
    valid = 1; ir = i_ir; alu = a; pc = p;
    rdata = rd_w;
    @(negedge clk);
    // Junk valid while busy must be ignored.
    ir = $urandom; alu = $urandom;
    k = 0; seen = 0; early = 0;
    while (k < 40 && !seen) begin
      if (done) seen = 1;
      else begin
        if (rf_load) early = 1;
        if (k == 1) valid = 0;
        ack = (k == ackc);
        @(negedge clk);
        k++;
      end
    end
    valid = 0; ack = 0;
    obs_data = rf_data;
    obs_load = rf_load;
    obs_err = err;
    if (!seen) chk("done_timeout", 32'(seen), 32'd1);
    else begin
      chk("latency", k, ek);
      chk("rf_load", 32'(rf_load), 32'(eld));
      chk("err", 32'(err), 32'(eer));
      chk("rf_IR", rf_ir, i_ir);
      chk("early_load", 32'(early), 32'd0);
      if (eld) chk("rf_data", rf_data, ed);
    end
    @(negedge clk);
    chk("idle_ready", 32'(ready), 32'd1);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_load", 32'(rf_load), 32'd0);
  endtask

  localparam logic [6:0] OPS [15] = '{
    7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63,
    7'h23, 7'h73, 7'h0F, 7'h03, 7'h03, 7'h03,
    7'h7F, 7'h00
  };

  initial begin
    logic [31:0] sv7;
    logic [6:0] op;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rst = 1; valid = 0; ir = 0; alu = 0; pc = 0;
    rdata = 0; ack = 0;
    #12;
    chk("rst_IR", rf_ir, 32'd0);
    chk("rst_load", 32'(rf_load), 32'd0);
    chk("rst_data", rf_data, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);

    run(32'h00A28293, 32'h2A, 32'h100, 0, 99);
    chk("addi_data", obs_data, 32'h2A);
    chk("x5", rf[5], 32'h2A);

    run(32'h00000303, 32'h1003, 0, 32'h80FFFFFF, 4);
    chk("lb_data", obs_data, 32'hFFFFFF80);
    run(32'h00004303, 32'h1003, 0, 32'h80FFFFFF, 4);
    chk("lbu_data", obs_data, 32'h00000080);

    run(32'h00001303, 32'h1001, 0, 0, 1);
    chk("lh_mis_err", 32'(obs_err), 32'd1);
    run(32'h00002303, 32'h1000, 0, 32'h12345678, 2);
    chk("lw_data", obs_data, 32'h12345678);

    run(32'h000000EF, 32'h0, 32'hFFFFFFFC, 0, 99);
    chk("jal_wrap", obs_data, 32'h0);
    run(32'h00000063, 32'h5, 0, 0, 99);
    run(32'h00000033, 32'h5, 0, 0, 99);

    run(32'h00002383, 32'h2000, 0, 32'hDEAD, 99);
    chk("tmo_err", 32'(obs_err), 32'd1);
    ack = 1;
    @(negedge clk);
    ack = 0;
    chk("late_ack_load", 32'(rf_load), 32'd0);
    chk("late_ack_ready", 32'(ready), 32'd1);
    run(32'h00002383, 32'h2004, 0, 32'h5A5A, T);
    chk("ack_at_tmo", obs_data, 32'h5A5A);

    sv7 = rf[7];
    valid = 1; ir = 32'h00002383; alu = 32'h3000;
    @(negedge clk);
    valid = 0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("mid_rst_IR", rf_ir, 32'd0);
    chk("mid_rst_load", 32'(rf_load), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 0;
    rdata = 32'hBAD0BAD0; ack = 1;
    @(negedge clk);
    ack = 0;
    chk("post_rst_ready", 32'(ready), 32'd1);
    chk("post_rst_load", 32'(rf_load), 32'd0);
    chk("x7_kept", rf[7], sv7);

    for (int n = 0; n < 150; n++) begin
      op = OPS[$urandom_range(0, 14)];
      run({$urandom_range(0, 131071),
           3'($urandom_range(0, 7)),
           5'($urandom_range(0, 31)), op},
          $urandom, $urandom, $urandom,
          $urandom_range(1, T + 3));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
